// File: rtl/dcache_pkg.sv
// Shared dcache types and geometry: set/column/tag sizing, eviction FSM states
// and the victim line payload handed to the victim cache.
package dcache_pkg;

  localparam int unsigned DCACHE_NO_OF_SETS = 2048;
  localparam int unsigned DCACHE_NUM_COL    = 16;
  localparam int unsigned DCACHE_COL_WIDTH  = 8;
  localparam int unsigned DCACHE_TAG_WIDTH  = 20;
  localparam int unsigned DCACHE_ADDR_WIDTH = $clog2(DCACHE_NO_OF_SETS);
  localparam int unsigned DCACHE_DATA_WIDTH = DCACHE_NUM_COL * DCACHE_COL_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_SEND    = 2'd3
  } evict_state_e;

  typedef struct packed {
    logic [DCACHE_TAG_WIDTH-1:0]  tag;
    logic [DCACHE_ADDR_WIDTH-1:0] set;
    logic                         dirty;
    logic [DCACHE_DATA_WIDTH-1:0] line;
  } victim_line_t;

endpackage

// File: rtl/dcache_evict_buf.sv
// Single-entry holding register for one victim line, presented to the victim
// cache with valid/ready. Header and line data are loaded at different times.
module dcache_evict_buf
  import dcache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_hdr_load,
  input  logic [DCACHE_TAG_WIDTH-1:0]  i_tag,
  input  logic [DCACHE_ADDR_WIDTH-1:0] i_set,
  input  logic                         i_dirty,
  input  logic                         i_line_load,
  input  logic [DCACHE_DATA_WIDTH-1:0] i_line,
  input  logic                         i_push,
  input  logic                         i_ready,
  output logic                         o_valid,
  output logic [DCACHE_TAG_WIDTH-1:0]  o_tag,
  output logic [DCACHE_ADDR_WIDTH-1:0] o_set,
  output logic                         o_dirty,
  output logic [DCACHE_DATA_WIDTH-1:0] o_line
);

  victim_line_t r_entry;
  logic         r_valid;

  // Header is only reloaded when the entry is empty or being drained this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_hdr_load) begin
        r_entry.tag   <= i_tag;
        r_entry.set   <= i_set;
        r_entry.dirty <= i_dirty;
      end
      if (i_line_load) begin
        r_entry.line <= i_line;
      end
      if (i_push) begin
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_tag   = r_entry.tag;
  assign o_set   = r_entry.set;
  assign o_dirty = r_entry.dirty;
  assign o_line  = r_entry.line;

endmodule

// File: rtl/dcache_evict_reader.sv
// Eviction read initiator: reads one victim line from the dcache data RAM by
// set index and forwards it with its tag to the victim cache.
module dcache_evict_reader
  import dcache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         evict_req_i,
  input  logic [DCACHE_ADDR_WIDTH-1:0] evict_set_i,
  input  logic [DCACHE_TAG_WIDTH-1:0]  evict_tag_i,
  input  logic                         evict_dirty_i,
  output logic                         evict_ack_o,
  output logic                         busy_o,
  output logic                         ram_req_o,
  input  logic                         ram_gnt_i,
  output logic [DCACHE_NUM_COL-1:0]    ram_wr_en_o,
  output logic [DCACHE_ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DCACHE_DATA_WIDTH-1:0] ram_rdata_i,
  output logic                         vc_valid_o,
  input  logic                         vc_ready_i,
  output logic [DCACHE_DATA_WIDTH-1:0] vc_line_o,
  output logic [DCACHE_TAG_WIDTH-1:0]  vc_tag_o,
  output logic [DCACHE_ADDR_WIDTH-1:0] vc_set_o,
  output logic                         vc_dirty_o,
  output logic [31:0]                  evict_cnt_o
);

  evict_state_e r_state;
  evict_state_e w_state_nxt;
  logic         w_ack;
  logic         w_line_load;
  logic         w_push;
  logic         w_hs;
  logic [31:0]  r_evict_cnt;

  assign w_hs = vc_valid_o & vc_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; a new request is only taken when idle or as the current line drains.
  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_line_load = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (evict_req_i) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (ram_gnt_i) begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        w_line_load = 1'b1;
        w_push      = 1'b1;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (w_hs) begin
          if (evict_req_i) begin
            w_ack       = 1'b1;
            w_state_nxt = ST_RD_REQ;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  dcache_evict_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_hdr_load  (w_ack),
    .i_tag       (evict_tag_i),
    .i_set       (evict_set_i),
    .i_dirty     (evict_dirty_i),
    .i_line_load (w_line_load),
    .i_line      (ram_rdata_i),
    .i_push      (w_push),
    .i_ready     (vc_ready_i),
    .o_valid     (vc_valid_o),
    .o_tag       (vc_tag_o),
    .o_set       (vc_set_o),
    .o_dirty     (vc_dirty_o),
    .o_line      (vc_line_o)
  );

  // Completed-transfer counter, sticks at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evict_cnt <= '0;
    end else if (w_hs && (r_evict_cnt != '1)) begin
      r_evict_cnt <= r_evict_cnt + 32'd1;
    end
  end

  assign evict_ack_o = w_ack;
  assign busy_o      = (r_state != ST_IDLE);
  assign ram_req_o   = (r_state == ST_RD_REQ);
  assign ram_addr_o  = vc_set_o;
  assign ram_wr_en_o = '0;
  assign evict_cnt_o = r_evict_cnt;

endmodule

// File: tb/tb_dcache_evict_reader.sv
// Bench for dcache_evict_reader: directed scenarios plus randomized traffic
// scored against a cycle-timeline model and a behavioural data RAM.
module tb_dcache_evict_reader;
  import dcache_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         evict_req_i;
  logic [DCACHE_ADDR_WIDTH-1:0] evict_set_i;
  logic [DCACHE_TAG_WIDTH-1:0]  evict_tag_i;
  logic                         evict_dirty_i;
  logic                         evict_ack_o;
  logic                         busy_o;
  logic                         ram_req_o;
  logic                         ram_gnt_i;
  logic [DCACHE_NUM_COL-1:0]    ram_wr_en_o;
  logic [DCACHE_ADDR_WIDTH-1:0] ram_addr_o;
  logic [DCACHE_DATA_WIDTH-1:0] ram_rdata_i;
  logic                         vc_valid_o;
  logic                         vc_ready_i;
  logic [DCACHE_DATA_WIDTH-1:0] vc_line_o;
  logic [DCACHE_TAG_WIDTH-1:0]  vc_tag_o;
  logic [DCACHE_ADDR_WIDTH-1:0] vc_set_o;
  logic                         vc_dirty_o;
  logic [31:0]                  evict_cnt_o;

  logic [DCACHE_DATA_WIDTH-1:0] mem [DCACHE_NO_OF_SETS];
  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;

  dcache_evict_reader dut (
    .clk           (clk),
    .rst           (rst),
    .evict_req_i   (evict_req_i),
    .evict_set_i   (evict_set_i),
    .evict_tag_i   (evict_tag_i),
    .evict_dirty_i (evict_dirty_i),
    .evict_ack_o   (evict_ack_o),
    .busy_o        (busy_o),
    .ram_req_o     (ram_req_o),
    .ram_gnt_i     (ram_gnt_i),
    .ram_wr_en_o   (ram_wr_en_o),
    .ram_addr_o    (ram_addr_o),
    .ram_rdata_i   (ram_rdata_i),
    .vc_valid_o    (vc_valid_o),
    .vc_ready_i    (vc_ready_i),
    .vc_line_o     (vc_line_o),
    .vc_tag_o      (vc_tag_o),
    .vc_set_o      (vc_set_o),
    .vc_dirty_o    (vc_dirty_o),
    .evict_cnt_o   (evict_cnt_o)
  );

  always #5 clk = ~clk;

  // Registered-read RAM; outside a granted access the read port carries junk.
  always @(posedge clk) begin
    if (ram_req_o && ram_gnt_i) ram_rdata_i <= mem[ram_addr_o];
    else ram_rdata_i <= {$urandom, $urandom, $urandom, $urandom};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ack"},   evict_ack_o, 0);
    check({pfx, "_busy"},  busy_o, 0);
    check({pfx, "_rreq"},  ram_req_o, 0);
    check({pfx, "_wren"},  ram_wr_en_o, 0);
    check({pfx, "_addr"},  ram_addr_o, 0);
    check({pfx, "_valid"}, vc_valid_o, 0);
    check({pfx, "_line"},  vc_line_o, 0);
    check({pfx, "_tag"},   vc_tag_o, 0);
    check({pfx, "_set"},   vc_set_o, 0);
    check({pfx, "_dirty"}, vc_dirty_o, 0);
    check({pfx, "_cnt"},   evict_cnt_o, 0);
  endtask

  // Unstalled eviction starting at a drive point of an idle cycle (grant=1, ready=1).
  task automatic evict_fast(input logic [10:0] set, input logic [19:0] tag,
                            input logic dirty, input logic [31:0] cnt_after);
    evict_req_i = 1'b1; evict_set_i = set; evict_tag_i = tag; evict_dirty_i = dirty;
    #1 check("fast_ack_c0", evict_ack_o, 1);
    step(); evict_req_i = 1'b0;
    #1 check("fast_rreq_c1", ram_req_o, 1);
    check("fast_addr_c1", ram_addr_o, set);
    step();
    #1 check("fast_valid_c2", vc_valid_o, 0);
    step();
    #1 check("fast_valid_c3", vc_valid_o, 1);
    check("fast_line", vc_line_o, mem[set]);
    check("fast_tag", vc_tag_o, tag);
    check("fast_set", vc_set_o, set);
    check("fast_dirty", vc_dirty_o, dirty);
    step();
    #1 check("fast_cnt", evict_cnt_o, cnt_after);
    check("fast_idle", busy_o, 0);
  endtask

  // Random-phase reference timeline
  bit                           have_txn;
  int                           t_ack;
  int                           t_gnt;
  logic [31:0]                  m_cnt;
  logic [DCACHE_DATA_WIDTH-1:0] e_line;
  logic [DCACHE_TAG_WIDTH-1:0]  e_tag;
  logic [DCACHE_ADDR_WIDTH-1:0] e_set;
  logic                         e_dirty;
  bit exp_rreq, exp_valid, hs, exp_ack, acked;

  initial begin
    for (int i = 0; i < int'(DCACHE_NO_OF_SETS); i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[5] = 128'h00112233445566778899AABBCCDDEEFF;

    rst = 1'b1; evict_req_i = 1'b0; evict_set_i = '0; evict_tag_i = '0;
    evict_dirty_i = 1'b0; ram_gnt_i = 1'b1; vc_ready_i = 1'b1;
    step(); step();
    rst = 1'b0;
    #1 check_all_zero("reset");

    // Clean eviction
    step();
    evict_fast(11'h005, 20'h12345, 1'b1, 32'd1);

    // Grant stall for five cycles
    step();
    ram_gnt_i = 1'b0;
    evict_req_i = 1'b1; evict_set_i = 11'h123; evict_tag_i = 20'hABCDE; evict_dirty_i = 1'b0;
    #1 check("stall_ack", evict_ack_o, 1);
    for (int k = 0; k < 5; k++) begin
      step(); evict_req_i = 1'b0;
      #1 check("stall_rreq", ram_req_o, 1);
      check("stall_addr", ram_addr_o, 11'h123);
      check("stall_wren", ram_wr_en_o, 0);
      check("stall_valid", vc_valid_o, 0);
    end
    step(); ram_gnt_i = 1'b1;
    #1 check("stall_rreq_gnt", ram_req_o, 1);
    step();
    #1 check("stall_valid_gnt1", vc_valid_o, 0);
    check("stall_rreq_off", ram_req_o, 0);
    step();
    #1 check("stall_valid_gnt2", vc_valid_o, 1);
    check("stall_line", vc_line_o, mem[11'h123]);
    check("stall_wren_end", ram_wr_en_o, 0);
    step();
    #1 check("stall_cnt", evict_cnt_o, 32'd2);

    // Backpressure, with ignored requests while stalled in SEND
    step();
    vc_ready_i = 1'b0;
    evict_req_i = 1'b1; evict_set_i = 11'h02A; evict_tag_i = 20'h0F0F0; evict_dirty_i = 1'b1;
    #1 check("bp_ack", evict_ack_o, 1);
    step(); evict_req_i = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      evict_req_i = (k < 3); evict_set_i = 11'h03C; evict_tag_i = 20'h11111; evict_dirty_i = 1'b0;
      #1 check("bp_valid", vc_valid_o, 1);
      check("bp_line", vc_line_o, mem[11'h02A]);
      check("bp_tag", vc_tag_o, 20'h0F0F0);
      check("bp_set", vc_set_o, 11'h02A);
      check("bp_dirty", vc_dirty_o, 1);
      check("bp_cnt", evict_cnt_o, 32'd2);
      check("bp_no_ack", evict_ack_o, 0);
    end
    step(); vc_ready_i = 1'b1;
    #1 check("bp_valid_rdy", vc_valid_o, 1);
    check("bp_ack_rdy", evict_ack_o, 0);
    step();
    #1 check("bp_idle", busy_o, 0);
    check("bp_valid_done", vc_valid_o, 0);
    check("bp_cnt_done", evict_cnt_o, 32'd3);

    // Back-to-back
    step();
    evict_req_i = 1'b1; evict_set_i = 11'h010; evict_tag_i = 20'hAAAAA; evict_dirty_i = 1'b1;
    #1 check("b2b_ack0", evict_ack_o, 1);
    step(); evict_req_i = 1'b0;
    step();
    step();
    evict_req_i = 1'b1; evict_set_i = 11'h7FF; evict_tag_i = 20'hBBBBB; evict_dirty_i = 1'b0;
    #1 check("b2b_valid0", vc_valid_o, 1);
    check("b2b_set0", vc_set_o, 11'h010);
    check("b2b_ack_hs", evict_ack_o, 1);
    step(); evict_req_i = 1'b0;
    #1 check("b2b_busy", busy_o, 1);
    check("b2b_rreq", ram_req_o, 1);
    check("b2b_addr", ram_addr_o, 11'h7FF);
    check("b2b_cnt1", evict_cnt_o, 32'd4);
    step();
    step();
    #1 check("b2b_valid1", vc_valid_o, 1);
    check("b2b_set1", vc_set_o, 11'h7FF);
    check("b2b_line1", vc_line_o, mem[11'h7FF]);
    check("b2b_tag1", vc_tag_o, 20'hBBBBB);
    check("b2b_dirty1", vc_dirty_o, 0);
    step();
    #1 check("b2b_cnt2", evict_cnt_o, 32'd5);

    // Reset while the read is in flight
    step();
    evict_req_i = 1'b1; evict_set_i = 11'h044; evict_tag_i = 20'h44444; evict_dirty_i = 1'b1;
    step(); evict_req_i = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    #1 check_all_zero("midrst");
    step();
    evict_fast(11'h066, 20'h66666, 1'b0, 32'd1);

    // Counter saturation
    step();
    force dut.r_evict_cnt = 32'hFFFF_FFFE;
    step();
    release dut.r_evict_cnt;
    #1 check("sat_preset", evict_cnt_o, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      step();
      evict_fast(11'($urandom), 20'($urandom), 1'($urandom), 32'hFFFF_FFFF);
    end

    // Randomized traffic against the timeline model
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    have_txn = 1'b0; t_ack = 0; t_gnt = -1; m_cnt = '0; acked = 1'b0;
    e_line = '0; e_tag = '0; e_set = '0; e_dirty = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      if (acked) evict_req_i = 1'b0;
      acked = 1'b0;
      ram_gnt_i  = ($urandom_range(3) != 0);
      vc_ready_i = ($urandom_range(2) != 0);
      if (!evict_req_i && ($urandom_range(1) != 0)) begin
        evict_req_i = 1'b1;
        evict_set_i = 11'($urandom);
        evict_tag_i = 20'($urandom);
        evict_dirty_i = 1'($urandom);
      end
      #1;
      exp_rreq  = have_txn && (t_gnt < 0) && (cyc > t_ack);
      exp_valid = have_txn && (t_gnt >= 0) && (cyc >= t_gnt + 2);
      hs        = exp_valid && vc_ready_i;
      exp_ack   = evict_req_i && (!have_txn || hs);
      check("rnd_ack", evict_ack_o, exp_ack);
      check("rnd_rreq", ram_req_o, exp_rreq);
      check("rnd_valid", vc_valid_o, exp_valid);
      check("rnd_busy", busy_o, have_txn && (cyc > t_ack));
      check("rnd_cnt", evict_cnt_o, m_cnt);
      if (exp_rreq) check("rnd_addr", ram_addr_o, e_set);
      if (exp_valid) begin
        check("rnd_line", vc_line_o, e_line);
        check("rnd_tag", vc_tag_o, e_tag);
        check("rnd_set", vc_set_o, e_set);
        check("rnd_dirty", vc_dirty_o, e_dirty);
      end
      if (exp_rreq && ram_gnt_i) t_gnt = cyc;
      if (hs) begin
        have_txn = 1'b0;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      if (exp_ack) begin
        have_txn = 1'b1;
        t_ack = cyc;
        t_gnt = -1;
        e_set = evict_set_i;
        e_tag = evict_tag_i;
        e_dirty = evict_dirty_i;
        e_line = mem[evict_set_i];
        acked = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
